// File: rtl/conv_enc_213_pkg.sv
// Shared (2,1,3) convolutional code parameters for the encoder and the Viterbi decoder.
// Code geometry, default generators, FSM state encoding and the branch-label function.
package conv_enc_213_pkg;

    localparam int ENC_N   = 2;   // code bits per symbol
    localparam int ENC_KIN = 1;   // information bits per symbol
    localparam int ENC_CL  = 3;   // constraint length
    localparam int ENC_M   = 2;   // encoder memory

    localparam logic [ENC_CL-1:0] G0_DEFAULT = 3'b111;
    localparam logic [ENC_CL-1:0] G1_DEFAULT = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TAIL  = 2'd2,
        ST_DRAIN = 2'd3
    } enc_state_e;

    // Window bit ENC_CL-1 is the newest input, bit 0 the oldest.
    function automatic logic [ENC_N-1:0] enc_symbol(
        input logic [ENC_CL-1:0] win,
        input logic [ENC_CL-1:0] g0,
        input logic [ENC_CL-1:0] g1
    );
        return {^(win & g0), ^(win & g1)};
    endfunction

endpackage

// File: rtl/enc_213_core.sv
// Combinational window-to-symbol map of the (2,1,3) code.
// Also serves as the branch-label reference for the decoder.
module enc_213_core
    import conv_enc_213_pkg::*;
#(
    parameter logic [ENC_CL-1:0] G0 = G0_DEFAULT,
    parameter logic [ENC_CL-1:0] G1 = G1_DEFAULT
) (
    input  logic [ENC_CL-1:0] win,
    output logic [ENC_N-1:0]  sym
);

    always_comb begin
        sym = enc_symbol(win, G0, G1);
    end

endmodule

// File: rtl/conv_enc_213.sv
// Framed serial rate-1/2 (2,1,3) convolutional encoder with valid/ready on both sides.
// Define ENC_TAIL_EN to append two zero tail bits so each frame ends in state 00.
module conv_enc_213
    import conv_enc_213_pkg::*;
#(
    parameter int                FRAME_LEN_W = 8,
    parameter logic [ENC_CL-1:0] G0          = G0_DEFAULT,
    parameter logic [ENC_CL-1:0] G1          = G1_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [FRAME_LEN_W-1:0] frame_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_bit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ENC_N-1:0]       out_sym,
    output logic                   out_last,
    output logic                   busy,
    output logic                   err_start
);

    enc_state_e             state;
    logic [ENC_M-1:0]       sr;
    logic [FRAME_LEN_W-1:0] cnt;
    logic [FRAME_LEN_W-1:0] len_q;
`ifdef ENC_TAIL_EN
    logic                   tail_idx;
`endif

    logic                   load_ok;
    logic                   accept;
    logic [ENC_CL-1:0]      win;
    logic [ENC_N-1:0]       sym_next;
    logic [FRAME_LEN_W-1:0] cnt_next;
    logic                   last_data;

    // Single output register, no skid buffer: a new symbol may load only
    // when the register is empty or being emptied this cycle.
    assign load_ok   = !out_valid || out_ready;
    assign in_ready  = (state == ST_DATA) && load_ok;
    assign accept    = in_valid && in_ready;
    assign busy      = (state != ST_IDLE);
    assign cnt_next  = cnt + FRAME_LEN_W'(ENC_KIN);
    assign last_data = (cnt_next == len_q);

    always_comb begin
        win = {in_bit, sr};
        if (state == ST_TAIL) begin
            win = {1'b0, sr};
        end
    end

    enc_213_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .win (win),
        .sym (sym_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sr        <= '0;
            cnt       <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_last  <= 1'b0;
            err_start <= 1'b0;
`ifdef ENC_TAIL_EN
            tail_idx  <= 1'b0;
`endif
        end else begin
            err_start <= 1'b0;
            if (start && (state != ST_IDLE)) begin
                err_start <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (frame_len != '0) begin
                            len_q <= frame_len;
                            sr    <= '0;
                            cnt   <= '0;
                            state <= ST_DATA;
                        end else begin
                            err_start <= 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (accept) begin
                        out_sym   <= sym_next;
                        out_valid <= 1'b1;
                        sr        <= {in_bit, sr[ENC_M-1:1]};
                        cnt       <= cnt_next;
                        out_last  <= 1'b0;
                        if (last_data) begin
`ifdef ENC_TAIL_EN
                            tail_idx <= 1'b0;
                            state    <= ST_TAIL;
`else
                            out_last <= 1'b1;
                            state    <= ST_DRAIN;
`endif
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end

`ifdef ENC_TAIL_EN
                ST_TAIL: begin
                    if (load_ok) begin
                        out_sym   <= sym_next;
                        out_valid <= 1'b1;
                        sr        <= {1'b0, sr[ENC_M-1:1]};
                        if (tail_idx) begin
                            out_last <= 1'b1;
                            state    <= ST_DRAIN;
                        end else begin
                            tail_idx <= 1'b1;
                        end
                    end
                end
`endif

                ST_DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/conv_enc_213.md
Name: conv_enc_213

Overview:
- Serial rate-1/2 convolutional encoder for the (2,1,3) code, constraint length 3, memory 2. It is the transmit-side counterpart of the backward-label Viterbi decoder (branch metrics, ACS, traceback).
- Takes one information bit per valid/ready handshake and emits one 2-bit code symbol per bit.
- Frames data, and optionally appends zero tail bits so every frame ends in state 00, which the decoder traceback expects.

Parameters:
- FRAME_LEN_W, 8: width of the frame length field and of the bit counter.
- G0, 3'b111: generator for out_sym[1], octal 7. Bit 2 taps the current input, bit 1 the previous bit, bit 0 the bit before that.
- G1, 3'b101: generator for out_sym[0], octal 5. Same tap ordering.

Ports:
- clk, input, 1: rising-edge clock, the only clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle request to begin a frame; sampled only in IDLE.
- frame_len, input, FRAME_LEN_W: number of information bits; sampled with start.
- in_valid, input, 1: in_bit is valid.
- in_ready, output, 1: encoder accepts in_bit this cycle.
- in_bit, input, 1: information bit.
- out_valid, output, 1: out_sym is valid.
- out_ready, input, 1: downstream accepts out_sym.
- out_sym, output, 2: code symbol, {G0 output, G1 output}.
- out_last, output, 1: marks the final symbol of the frame; qualified by out_valid.
- busy, output, 1: high while the state is not IDLE.
- err_start, output, 1: one-cycle pulse when a start is rejected.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, sr=2'b00, cnt=0.
  - out_valid=0, out_sym=2'b00, out_last=0, in_ready=0, busy=0, err_start=0.
  - Reset during a frame aborts it immediately. Any pending symbol is dropped and no out_last is issued.
- States: IDLE, DATA, TAIL, DRAIN.
- IDLE:
  - start with frame_len!=0: latch frame_len, clear sr to 00, set cnt=0, go to DATA.
  - start with frame_len==0: stay in IDLE and pulse err_start.
- in_ready = (state==DATA) && (!out_valid || out_ready). It is combinational from registered state and out_ready. There is a single output register and no skid buffer.
- Input handshake (in_valid && in_ready):
  - Form the window w = {in_bit, sr[1], sr[0]}.
  - On the next edge: out_sym <= {^(w&G0), ^(w&G1)}, out_valid <= 1, sr <= {in_bit, sr[1]}, cnt <= cnt+1.
  - Latency from input handshake to out_valid is 1 cycle. Throughput is 1 bit per cycle when out_ready is held high.
- DATA exit, when the handshake accepts bit number frame_len:
  - With ENC_TAIL_EN defined: go to TAIL.
  - Without it: set out_last with that symbol and go to DRAIN.
- TAIL:
  - Encodes 2 internal zero bits (w = {0, sr}) with the same load rule as DATA: load when !out_valid || out_ready.
  - The input side is not used.
  - The second tail symbol carries out_last=1. After it loads, go to DRAIN.
- DRAIN: hold until the final symbol handshakes (out_valid && out_ready), then return to IDLE. At that point sr==00 is guaranteed when tail termination is enabled.
- Output hold rule: while out_valid && !out_ready, out_sym and out_last are held stable. out_valid drops on a handshake with no new load.
- Rejected starts: start outside IDLE is ignored and pulses err_start for 1 cycle. It does not disturb the frame in progress.
- Counters: cnt is FRAME_LEN_W bits and never wraps within a frame. The maximum frame length is 2^FRAME_LEN_W-1.

Optional Feature:
- Macro: ENC_TAIL_EN.
- Defined: zero-tail termination as described above. A frame of L bits produces L+2 symbols and ends in state 00.
- Undefined: truncated frames. A frame produces exactly L symbols, out_last goes on data symbol L, and sr is still cleared at the next start.

Decomposition:
- Shared parameter include, alongside the decoder parameters:
  - n=2, k=1, K=3, m=2.
  - Default generators 3'b111 and 3'b101.
  - State-encoding constants for IDLE, DATA, TAIL, DRAIN.
- One natural sub-module, enc_213_core: combinational window-to-symbol mapping (w, G0, G1 -> 2-bit symbol). It is reusable as the decoder's branch-label reference model.
- The FSM and handshake stay in conv_enc_213.

Test Plan:
1. Basic frame, ENC_TAIL_EN defined, out_ready=1:
   - Stimulus: start, frame_len=4, bits 1,0,1,1.
   - Required: out_sym sequence 11,10,00,01,01,11; out_last only on the 6th symbol; busy falls the cycle after.
2. Truncated frame, ENC_TAIL_EN undefined:
   - Stimulus: same stimulus as scenario 1.
   - Required: symbols 11,10,00,01; out_last on the 4th symbol; no tail symbols.
3. Backpressure:
   - Stimulus: as scenario 1, with out_ready low for 3 cycles after the 2nd symbol.
   - Required: out_sym=10 held stable; in_ready=0 throughout; the final sequence is unchanged.
4. Rejected starts:
   - Stimulus: start with frame_len=0 in IDLE, then start with frame_len=5 while busy.
   - Required: one err_start pulse each; state and output of the running frame unaffected.
5. Reset mid-frame:
   - Stimulus: assert rst_n low after the 2nd input bit, release, then run a new frame of bits 1,1.
   - Required: outputs clear immediately; the new frame gives 11,01,01,11 with no residue from the aborted frame.
6. Back-to-back frames:
   - Stimulus: assert start in the cycle IDLE is re-entered after the final symbol's handshake; frame_len=1, bit 1.
   - Required: symbols 11,10,11 with out_last on the 3rd.
